melody_seq: RTL and testbench
=============================

# melody_seq

Note sequencer that sits directly upstream of the square-wave tone generator. It plays a fixed 16-entry song table, one note at a time. For each note it supplies the tone generator with a half-period-free full period count (`tone_period`), an enable (`tone_en`) and a realign pulse (`tone_start`). It also times note durations in beats and inserts a short silent articulation gap between notes. Playback is controlled by debounced single-cycle key pulses.

## Interface
- `BEAT_CNT_MAX`, 25'd12_499_999, cycles per beat minus 1 (250 ms at 50 MHz)
- `GAP_CNT_MAX`, 20'd999_999, cycles per inter-note gap minus 1 (20 ms)
- `SONG_LEN`, 5'd16, number of table entries played (1..16)
- `LOOP_EN`, 1'b1, 1 = wrap to entry 0 after last entry; 0 = stop
- `sys_clk`  in  1  system clock
- `sys_rst_n`  in  1  reset, asynchronous, active-low
- `key_play`  in  1  1-cycle pulse: start or restart from entry 0
- `key_stop`  in  1  1-cycle pulse: abort to idle
- `tone_period`  out  18  full period count for the tone generator; 0 when idle
- `tone_en`  out  1  1 = tone generator may toggle; 0 = silence
- `tone_start`  out  1  1-cycle pulse on the first PLAY cycle of every note
- `note_idx`  out  4  table index currently loaded
- `busy`  out  1  1 in any state except IDLE
- `done`  out  1  1-cycle pulse when a non-looping song ends

## Operation
- Table entry format: `{note[3:0], beats[2:0]}`.
  - `beats` 0 is treated as 1.
  - Note codes and periods:
    - 0 = rest, period 0
    - 1..7 = DO/RE/MI/FA/SO/LA/XI = 190839/170067/151514/143265/127550/113635/101213
    - 8..14 = same notes one octave up, base period >> 1 (8 → 95419)
    - 15 = rest
- Song table, in index order:
  - idx 0..13: DO1 DO1 SO1 SO1 LA1 LA1 SO2 FA1 FA1 MI1 MI1 RE1 RE1 DO2
  - idx 14: rest, 2 beats
  - idx 15: code 8, 1 beat
- States: IDLE, LOAD, PLAY, GAP.
  - **IDLE**: all outputs 0. `key_play` → LOAD with idx = 0.
  - **LOAD** (exactly 1 cycle):
    - `tone_period` ← lookup(note)
    - `beat_left` ← beats
    - `beat_cnt` ← 0
    - → PLAY
  - **PLAY**:
    - `tone_en` = 1 unless the note is a rest; `tone_start` = 1 on the first cycle only.
    - `beat_cnt` counts 0..BEAT_CNT_MAX. At max it clears and `beat_left` decrements.
    - At max with `beat_left` == 1 → GAP.
  - **GAP**:
    - `tone_en` = 0; `tone_period` is held.
    - `gap_cnt` counts 0..GAP_CNT_MAX. At max:
      - idx < SONG_LEN−1: idx+1 → LOAD
      - last entry, LOOP_EN = 1: idx = 0 → LOAD
      - last entry, LOOP_EN = 0: `done` pulse → IDLE
- Priority: `key_stop` > `key_play` > internal transitions.
  - `key_stop` in any state → IDLE next cycle; counters cleared, idx = 0.
  - `key_play` while busy → LOAD with idx = 0 (restart).
  - Both keys in the same cycle → IDLE.
- All outputs registered. Counters saturate-free: every counter is cleared on every state entry.

## Timing
- Reset values:
  - `tone_period` = 0, `tone_en` = 0, `tone_start` = 0
  - `note_idx` = 0, `busy` = 0, `done` = 0
  - state = IDLE
- `key_play` at cycle N:
  - `busy` = 1 and state = LOAD at N+1
  - `tone_start` = 1, `tone_en` = 1 and new `tone_period` valid at N+2
- Per-note length = 1 + beats·(BEAT_CNT_MAX+1) + (GAP_CNT_MAX+1) cycles.
- `note_idx` updates on entry to LOAD and is stable through PLAY and GAP.
- `done` is asserted in the same cycle `busy` falls.
- Reset mid-note: outputs go to reset values immediately, asynchronously.

## Test plan
All scenarios use BEAT_CNT_MAX = 9 and GAP_CNT_MAX = 3.
- **Reset hold**: release reset, idle 50 cycles → all outputs 0, state IDLE.
- **First note**: `key_play` at cycle 0.
  - Cycle 2: `tone_start` = 1, `tone_period` = 190839.
  - `tone_en` = 1 for cycles 2..11, 0 for 12..15.
  - Cycle 16: LOAD of idx 1.
- **Two-beat note**: idx 6 → `tone_period` 127550 with `tone_en` high for 20 cycles.
- **Rest and high octave**:
  - idx 14 → `tone_en` 0 for 20+4 cycles with `busy` = 1.
  - idx 15 → `tone_period` 95419.
- **End behaviour**:
  - LOOP_EN = 0: after idx 15 GAP, `done` pulses once and `busy` falls in the same cycle.
  - LOOP_EN = 1: next state is LOAD with `note_idx` = 0 and no `done` pulse.
- **Keys mid-play**:
  - `key_stop` during PLAY of idx 3 → next cycle all outputs 0.
  - `key_play` during GAP of idx 5 → LOAD with idx 0.
  - Simultaneous `key_play` + `key_stop` → IDLE.

Source files
------------

// File: rtl/melody_seq.sv
`default_nettype none
// ============================================================================
//  Module      : melody_seq
//  Description : Plays a fixed 16-entry song table and drives the square-wave
//                tone generator with a period, an enable and a realign pulse.
//                It times each note in beats and adds a silent gap after it.
//  Revision    : 1.0  initial release
// ============================================================================
module melody_seq #(
    parameter logic [24:0] BEAT_CNT_MAX = 25'd12_499_999,
    parameter logic [19:0] GAP_CNT_MAX  = 20'd999_999,
    parameter logic [4:0]  SONG_LEN     = 5'd16,
    parameter logic        LOOP_EN      = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_play,
    input  logic        key_stop,
    output logic [17:0] tone_period,
    output logic        tone_en,
    output logic        tone_start,
    output logic [3:0]  note_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Song table entry: {note[3:0], beats[2:0]}
    function automatic logic [6:0] song_entry(input logic [3:0] idx);
        logic [6:0] e;
        case (idx)
            4'd0:    e = {4'd1, 3'd1};   // DO
            4'd1:    e = {4'd1, 3'd1};   // DO
            4'd2:    e = {4'd5, 3'd1};   // SO
            4'd3:    e = {4'd5, 3'd1};   // SO
            4'd4:    e = {4'd6, 3'd1};   // LA
            4'd5:    e = {4'd6, 3'd1};   // LA
            4'd6:    e = {4'd5, 3'd2};   // SO, two beats
            4'd7:    e = {4'd4, 3'd1};   // FA
            4'd8:    e = {4'd4, 3'd1};   // FA
            4'd9:    e = {4'd3, 3'd1};   // MI
            4'd10:   e = {4'd3, 3'd1};   // MI
            4'd11:   e = {4'd2, 3'd1};   // RE
            4'd12:   e = {4'd2, 3'd1};   // RE
            4'd13:   e = {4'd1, 3'd2};   // DO, two beats
            4'd14:   e = {4'd0, 3'd2};   // rest, two beats
            default: e = {4'd8, 3'd1};   // high DO
        endcase
        return e;
    endfunction

    // Full period count per note code; codes 8..14 are one octave up
    function automatic logic [17:0] note_period(input logic [3:0] note);
        logic [17:0] base;
        case (note)
            4'd1, 4'd8:  base = 18'd190839;
            4'd2, 4'd9:  base = 18'd170067;
            4'd3, 4'd10: base = 18'd151514;
            4'd4, 4'd11: base = 18'd143265;
            4'd5, 4'd12: base = 18'd127550;
            4'd6, 4'd13: base = 18'd113635;
            4'd7, 4'd14: base = 18'd101213;
            default:     base = 18'd0;
        endcase
        if (note >= 4'd8) begin
            base = base >> 1;
        end
        return base;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [24:0] beat_cnt_q, beat_cnt_d;
    logic [2:0]  beat_left_q, beat_left_d;
    logic [19:0] gap_cnt_q, gap_cnt_d;
    logic [17:0] tone_period_q, tone_period_d;
    logic        tone_en_q, tone_en_d;
    logic        tone_start_q, tone_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [6:0]  cur_entry;
    logic [3:0]  cur_note;
    logic [2:0]  cur_beats;
    logic        cur_rest;
    logic        is_last;

    assign cur_entry = song_entry(idx_q);
    assign cur_note  = cur_entry[6:3];
    assign cur_beats = (cur_entry[2:0] == 3'd0) ? 3'd1 : cur_entry[2:0];
    assign cur_rest  = (cur_note == 4'd0) || (cur_note == 4'd15);
    assign is_last   = ({1'b0, idx_q} == (SONG_LEN - 5'd1));

    // Sequencer: keys override everything, otherwise step LOAD/PLAY/GAP
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        beat_cnt_d  = beat_cnt_q;
        beat_left_d = beat_left_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 1'b0;
        if (key_stop) begin
            state_d     = S_IDLE;
            idx_d       = 4'd0;
            beat_cnt_d  = 25'd0;
            beat_left_d = 3'd0;
            gap_cnt_d   = 20'd0;
        end else if (key_play) begin
            state_d     = S_LOAD;
            idx_d       = 4'd0;
            beat_cnt_d  = 25'd0;
            beat_left_d = 3'd0;
            gap_cnt_d   = 20'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    state_d     = S_PLAY;
                    beat_cnt_d  = 25'd0;
                    beat_left_d = cur_beats;
                    gap_cnt_d   = 20'd0;
                end
                S_PLAY: begin
                    if (beat_cnt_q == BEAT_CNT_MAX) begin
                        beat_cnt_d  = 25'd0;
                        beat_left_d = beat_left_q - 3'd1;
                        if (beat_left_q == 3'd1) begin
                            state_d   = S_GAP;
                            gap_cnt_d = 20'd0;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 25'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_CNT_MAX) begin
                        gap_cnt_d = 20'd0;
                        if (!is_last) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_LOAD;
                        end else if (LOOP_EN) begin
                            idx_d   = 4'd0;
                            state_d = S_LOAD;
                        end else begin
                            idx_d   = 4'd0;
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 20'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output registers are loaded from the upcoming state so they line up with it
    always_comb begin
        busy_d        = (state_d != S_IDLE);
        tone_start_d  = (state_q == S_LOAD) && (state_d == S_PLAY);
        tone_en_d     = (state_d == S_PLAY) && !cur_rest;
        tone_period_d = tone_period_q;
        if (state_d == S_IDLE) begin
            tone_period_d = 18'd0;
        end else if (tone_start_d) begin
            tone_period_d = note_period(cur_note);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= 4'd0;
            beat_cnt_q    <= 25'd0;
            beat_left_q   <= 3'd0;
            gap_cnt_q     <= 20'd0;
            tone_period_q <= 18'd0;
            tone_en_q     <= 1'b0;
            tone_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            beat_cnt_q    <= beat_cnt_d;
            beat_left_q   <= beat_left_d;
            gap_cnt_q     <= gap_cnt_d;
            tone_period_q <= tone_period_d;
            tone_en_q     <= tone_en_d;
            tone_start_q  <= tone_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign tone_period = tone_period_q;
    assign tone_en     = tone_en_q;
    assign tone_start  = tone_start_q;
    assign note_idx    = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_melody_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_melody_seq
//  Description : Directed self-checking bench for melody_seq with short beat
//                and gap counts; a looping and a non-looping instance share
//                the same stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_melody_seq;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        key_play;
    logic        key_stop;

    logic [17:0] tone_period, tone_period_nl;
    logic        tone_en, tone_en_nl;
    logic        tone_start, tone_start_nl;
    logic [3:0]  note_idx, note_idx_nl;
    logic        busy, busy_nl;
    logic        done, done_nl;

    int checks = 0;
    int errors = 0;

    melody_seq #(
        .BEAT_CNT_MAX(25'd9),
        .GAP_CNT_MAX (20'd3),
        .SONG_LEN    (5'd16),
        .LOOP_EN     (1'b1)
    ) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_play   (key_play),
        .key_stop   (key_stop),
        .tone_period(tone_period),
        .tone_en    (tone_en),
        .tone_start (tone_start),
        .note_idx   (note_idx),
        .busy       (busy),
        .done       (done)
    );

    melody_seq #(
        .BEAT_CNT_MAX(25'd9),
        .GAP_CNT_MAX (20'd3),
        .SONG_LEN    (5'd16),
        .LOOP_EN     (1'b0)
    ) u_dut_nl (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_play   (key_play),
        .key_stop   (key_stop),
        .tone_period(tone_period_nl),
        .tone_en    (tone_en_nl),
        .tone_start (tone_start_nl),
        .note_idx   (note_idx_nl),
        .busy       (busy_nl),
        .done       (done_nl)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_play();
        key_play = 1'b1;
        step();
        key_play = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_play  = 1'b0;
        key_stop  = 1'b0;
        repeat (3) step();
        sys_rst_n = 1'b1;
        repeat (50) step();
        checks++;
        if ({tone_period, tone_en, tone_start, note_idx, busy, done} !== 27'd0) begin
            errors++;
            $display("FAIL reset_loop: period=%0d en=%b start=%b idx=%0d busy=%b done=%b, want all 0",
                     tone_period, tone_en, tone_start, note_idx, busy, done);
        end
        checks++;
        if ({tone_period_nl, tone_en_nl, tone_start_nl, note_idx_nl, busy_nl, done_nl} !== 27'd0) begin
            errors++;
            $display("FAIL reset_noloop: period=%0d en=%b start=%b idx=%0d busy=%b done=%b, want all 0",
                     tone_period_nl, tone_en_nl, tone_start_nl, note_idx_nl, busy_nl, done_nl);
        end
    endtask

    // key_play at cycle 0; returns at cycle 16 (LOAD of idx 1)
    task automatic test_first_note();
        pulse_play();
        checks++;
        if (busy !== 1'b1 || note_idx !== 4'd0 || tone_en !== 1'b0 || tone_start !== 1'b0) begin
            errors++;
            $display("FAIL first_load: busy=%b idx=%0d en=%b start=%b, want busy=1 idx=0 en=0 start=0",
                     busy, note_idx, tone_en, tone_start);
        end
        step();
        checks++;
        if (tone_start !== 1'b1 || tone_en !== 1'b1 || tone_period !== 18'd190839) begin
            errors++;
            $display("FAIL first_play: start=%b en=%b period=%0d, want start=1 en=1 period=190839",
                     tone_start, tone_en, tone_period);
        end
        for (int c = 3; c <= 11; c++) begin
            step();
            checks++;
            if (tone_en !== 1'b1 || tone_start !== 1'b0) begin
                errors++;
                $display("FAIL first_beat cycle %0d: en=%b start=%b, want en=1 start=0", c, tone_en, tone_start);
            end
        end
        for (int c = 12; c <= 15; c++) begin
            step();
            checks++;
            if (tone_en !== 1'b0 || tone_period !== 18'd190839 || busy !== 1'b1) begin
                errors++;
                $display("FAIL first_gap cycle %0d: en=%b period=%0d busy=%b, want en=0 period=190839 busy=1",
                         c, tone_en, tone_period, busy);
            end
        end
        step();
        checks++;
        if (note_idx !== 4'd1 || busy !== 1'b1 || tone_en !== 1'b0) begin
            errors++;
            $display("FAIL first_next_load: idx=%0d busy=%b en=%b, want idx=1 busy=1 en=0", note_idx, busy, tone_en);
        end
    endtask

    // Entered on the LOAD cycle of idx; returns on the following LOAD cycle
    task automatic play_note(input int idx, input logic [17:0] per, input int beats, input logic rest);
        logic exp_en;
        exp_en = rest ? 1'b0 : 1'b1;
        checks++;
        if (note_idx !== idx[3:0] || busy !== 1'b1 || tone_en !== 1'b0) begin
            errors++;
            $display("FAIL load_%0d: idx=%0d busy=%b en=%b, want idx=%0d busy=1 en=0", idx, note_idx, busy, tone_en, idx);
        end
        step();
        checks++;
        if (tone_start !== 1'b1 || tone_period !== per) begin
            errors++;
            $display("FAIL start_%0d: start=%b period=%0d, want start=1 period=%0d", idx, tone_start, tone_period, per);
        end
        for (int c = 0; c < beats * 10; c++) begin
            checks++;
            if (tone_en !== exp_en || busy !== 1'b1 || note_idx !== idx[3:0] || (c > 0 && tone_start !== 1'b0)) begin
                errors++;
                $display("FAIL play_%0d cyc %0d: en=%b busy=%b idx=%0d start=%b, want en=%b busy=1", idx, c,
                         tone_en, busy, note_idx, tone_start, exp_en);
            end
            step();
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (tone_en !== 1'b0 || tone_period !== per || busy !== 1'b1 || tone_start !== 1'b0) begin
                errors++;
                $display("FAIL gap_%0d cyc %0d: en=%b period=%0d busy=%b start=%b, want en=0 period=%0d busy=1 start=0",
                         idx, c, tone_en, tone_period, busy, tone_start, per);
            end
            step();
        end
    endtask

    task automatic test_song();
        play_note(1,  18'd190839, 1, 1'b0);
        play_note(2,  18'd127550, 1, 1'b0);
        play_note(3,  18'd127550, 1, 1'b0);
        play_note(4,  18'd113635, 1, 1'b0);
        play_note(5,  18'd113635, 1, 1'b0);
        play_note(6,  18'd127550, 2, 1'b0);
        play_note(7,  18'd143265, 1, 1'b0);
        play_note(8,  18'd143265, 1, 1'b0);
        play_note(9,  18'd151514, 1, 1'b0);
        play_note(10, 18'd151514, 1, 1'b0);
        play_note(11, 18'd170067, 1, 1'b0);
        play_note(12, 18'd170067, 1, 1'b0);
        play_note(13, 18'd190839, 2, 1'b0);
        play_note(14, 18'd0,      2, 1'b1);
        play_note(15, 18'd95419,  1, 1'b0);
    endtask

    task automatic test_end();
        checks++;
        if (note_idx !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL loop_wrap: idx=%0d busy=%b done=%b, want idx=0 busy=1 done=0", note_idx, busy, done);
        end
        checks++;
        if (done_nl !== 1'b1 || busy_nl !== 1'b0 || note_idx_nl !== 4'd0 || tone_period_nl !== 18'd0) begin
            errors++;
            $display("FAIL noloop_done: done=%b busy=%b idx=%0d period=%0d, want done=1 busy=0 idx=0 period=0",
                     done_nl, busy_nl, note_idx_nl, tone_period_nl);
        end
        step();
        checks++;
        if (done_nl !== 1'b0 || busy_nl !== 1'b0) begin
            errors++;
            $display("FAIL noloop_after: done=%b busy=%b, want done=0 busy=0", done_nl, busy_nl);
        end
        checks++;
        if (tone_start !== 1'b1 || tone_period !== 18'd190839 || done !== 1'b0) begin
            errors++;
            $display("FAIL loop_replay: start=%b period=%0d done=%b, want start=1 period=190839 done=0",
                     tone_start, tone_period, done);
        end
    endtask

    task automatic test_keys_mid_play();
        pulse_play();
        repeat (49) step();
        checks++;
        if (note_idx !== 4'd3 || tone_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_stop: idx=%0d en=%b, want idx=3 en=1", note_idx, tone_en);
        end
        key_stop = 1'b1;
        step();
        key_stop = 1'b0;
        checks++;
        if ({tone_period, tone_en, tone_start, note_idx, busy, done} !== 27'd0) begin
            errors++;
            $display("FAIL stop_play: period=%0d en=%b start=%b idx=%0d busy=%b done=%b, want all 0",
                     tone_period, tone_en, tone_start, note_idx, busy, done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || tone_en !== 1'b0) begin
            errors++;
            $display("FAIL stop_stays: busy=%b en=%b, want busy=0 en=0", busy, tone_en);
        end
        pulse_play();
        repeat (87) step();
        checks++;
        if (note_idx !== 4'd5 || tone_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_restart: idx=%0d en=%b busy=%b, want idx=5 en=0 busy=1", note_idx, tone_en, busy);
        end
        key_play = 1'b1;
        step();
        key_play = 1'b0;
        checks++;
        if (note_idx !== 4'd0 || busy !== 1'b1 || tone_en !== 1'b0 || tone_start !== 1'b0) begin
            errors++;
            $display("FAIL restart_load: idx=%0d busy=%b en=%b start=%b, want idx=0 busy=1 en=0 start=0",
                     note_idx, busy, tone_en, tone_start);
        end
        step();
        checks++;
        if (tone_start !== 1'b1 || tone_en !== 1'b1 || tone_period !== 18'd190839) begin
            errors++;
            $display("FAIL restart_play: start=%b en=%b period=%0d, want start=1 en=1 period=190839",
                     tone_start, tone_en, tone_period);
        end
        repeat (3) step();
        key_play = 1'b1;
        key_stop = 1'b1;
        step();
        key_play = 1'b0;
        key_stop = 1'b0;
        checks++;
        if ({tone_period, tone_en, tone_start, note_idx, busy, done} !== 27'd0) begin
            errors++;
            $display("FAIL both_keys: period=%0d en=%b start=%b idx=%0d busy=%b done=%b, want all 0",
                     tone_period, tone_en, tone_start, note_idx, busy, done);
        end
    endtask

    task automatic test_async_reset();
        pulse_play();
        repeat (5) step();
        checks++;
        if (tone_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: en=%b busy=%b, want en=1 busy=1", tone_en, busy);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({tone_period, tone_en, tone_start, note_idx, busy, done} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset: period=%0d en=%b start=%b idx=%0d busy=%b done=%b, want all 0",
                     tone_period, tone_en, tone_start, note_idx, busy, done);
        end
        step();
        sys_rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || tone_en !== 1'b0 || tone_period !== 18'd0) begin
            errors++;
            $display("FAIL post_reset: busy=%b en=%b period=%0d, want busy=0 en=0 period=0", busy, tone_en, tone_period);
        end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_song();
        test_end();
        test_keys_mid_play();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
